// File: rtl/code_fetch_arbiter_pkg.sv
// code_fetch_arbiter_pkg: shared constants and types
// for the code-fetch port arbiter.
package code_fetch_arbiter_pkg;

  localparam int BEATS_DEF = 32;
  localparam logic [3:0] CF_PFX = 4'hA;
  localparam int TAG_LAST = 2;
  localparam int TAG_ID_HI = 1;
  localparam int TAG_ID_LO = 0;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/code_fetch_arbiter_if.sv
// code_fetch_arbiter_if: prefetcher-side, translation-side
// and return-path signals of the arbiter.
interface code_fetch_arbiter_if #(
  parameter int N = 2
);
  import code_fetch_arbiter_pkg::*;

  logic [N-1:0]    ACTI;
  logic [N*37-1:0] OFFSETI;
  logic [N*3-1:0]  TAGI;
  logic [N-1:0]    NEXTO;
  logic            ACT;
  logic [36:0]     OFFSET;
  logic [2:0]      TAGo;
  logic            NEXT;
  logic            DRDY;
  logic [8:0]      TAGi;
  logic [63:0]     DTi;
  logic [N-1:0]    DRDYO;
  logic [8:0]      TAGRO;
  logic [63:0]     DTRO;
  logic [1:0]      GNT;
  logic            BUSY;
  logic            SEQERR;

  modport slave (
    input  ACTI, OFFSETI, TAGI, NEXT,
    input  DRDY, TAGi, DTi,
    output NEXTO, ACT, OFFSET, TAGo,
    output DRDYO, TAGRO, DTRO,
    output GNT, BUSY, SEQERR
  );

  modport master (
    output ACTI, OFFSETI, TAGI, NEXT,
    output DRDY, TAGi, DTi,
    input  NEXTO, ACT, OFFSET, TAGo,
    input  DRDYO, TAGRO, DTRO,
    input  GNT, BUSY, SEQERR
  );

endinterface

// File: rtl/code_fetch_arbiter_rr_pick.sv
// rr_pick: first set request at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [1:0]   idx,
  output logic         vld
);

  int best;

  // pick the requester with the smallest rotated distance from ptr
  always_comb begin
    idx  = '0;
    vld  = |req;
    best = N;
    for (int j = 0; j < N; j++) begin
      if (req[j] && ((j - int'(ptr) + N) % N) < best) begin
        best = (j - int'(ptr) + N) % N;
        idx  = 2'(j);
      end
    end
  end

endmodule

// File: rtl/code_fetch_arbiter.sv
// code_fetch_arbiter: round-robin burst arbiter for the
// shared code-fetch port, with tagged return routing.
module code_fetch_arbiter
  import code_fetch_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int BEATS = BEATS_DEF
) (
  input logic CLK,
  input logic RESET,
  code_fetch_arbiter_if.slave bus
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t        st, st_nx;
  logic [1:0]    g, g_nx, ptr, ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          seqerr, err_nx;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [3:0]    acti4, lastv, nexto4, drdyo4, drdyo_nx;
  logic [36:0]   offs [4];
  logic          act_g, last_beat, busy, beat;
  logic          code, rtn_bad;
  logic [1:0]    rid;
  logic [8:0]    tagro;
  logic [63:0]   dtro;
  logic          unused_tag;

  assign unused_tag = ^bus.TAGI;

  for (genvar k = 0; k < 4; k++) begin : g_pad
    if (k < N) begin : g_on
      assign acti4[k] = bus.ACTI[k];
      assign lastv[k] = bus.TAGI[3*k+TAG_LAST];
      assign offs[k]  = bus.OFFSETI[37*k +: 37];
    end else begin : g_off
      assign acti4[k] = 1'b0;
      assign lastv[k] = 1'b0;
      assign offs[k]  = '0;
    end
  end

  rr_pick #(.N(N)) u_pick (
    .req (bus.ACTI),
    .ptr (ptr),
    .idx (pick),
    .vld (pick_vld)
  );

  assign busy      = (st == BURST);
  assign act_g     = acti4[g];
  assign last_beat = (cnt == CW'(BEATS-1));
  assign beat      = busy & act_g & bus.NEXT;

  assign code = (bus.TAGi[8:5] == CF_PFX);
  assign rid  = bus.TAGi[TAG_ID_HI:TAG_ID_LO];
  assign rtn_bad = bus.DRDY & code & (int'(rid) >= N);

  // grant, beat counting and protocol checks
  always_comb begin
    st_nx  = st;
    g_nx   = g;
    ptr_nx = ptr;
    cnt_nx = cnt;
    err_nx = seqerr | rtn_bad;
    unique case (st)
      IDLE: begin
        if (pick_vld) begin
          g_nx   = pick;
          ptr_nx = 2'((int'(pick) + 1) % N);
          st_nx  = BURST;
        end
      end
      BURST: begin
        if (!act_g) begin
          if (cnt != '0) err_nx = 1'b1;
          cnt_nx = '0;
          st_nx  = IDLE;
        end else if (bus.NEXT) begin
          if (lastv[g] != last_beat) err_nx = 1'b1;
          if (last_beat) begin
            cnt_nx = '0;
            st_nx  = IDLE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // FSM and grant state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st     <= IDLE;
      g      <= '0;
      ptr    <= '0;
      cnt    <= '0;
      seqerr <= 1'b0;
    end else begin
      st     <= st_nx;
      g      <= g_nx;
      ptr    <= ptr_nx;
      cnt    <= cnt_nx;
      seqerr <= err_nx;
    end
  end

  // beat accept steered to the owner only
  always_comb begin
    nexto4 = '0;
    if (beat) nexto4[g] = 1'b1;
  end

  // return routing: one-hot for code tags, broadcast otherwise
  always_comb begin
    drdyo4   = '0;
    drdyo_nx = '0;
    if (bus.DRDY) begin
      if (code) begin
        if (!rtn_bad) drdyo4[rid] = 1'b1;
        drdyo_nx = drdyo4;
      end else begin
        drdyo_nx = '1;
      end
    end
  end

  // registered return path
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.DRDYO <= '0;
      tagro     <= '0;
      dtro      <= '0;
    end else begin
      bus.DRDYO <= drdyo_nx[N-1:0];
      if (bus.DRDY) begin
        tagro <= code ? {bus.TAGi[8:2], 2'b00} : bus.TAGi;
        dtro  <= bus.DTi;
      end
    end
  end

  assign bus.NEXTO  = nexto4[N-1:0];
  assign bus.ACT    = busy & act_g;
  assign bus.OFFSET = offs[g];
  assign bus.TAGo   = {lastv[g], g};
  assign bus.TAGRO  = tagro;
  assign bus.DTRO   = dtro;
  assign bus.GNT    = g;
  assign bus.BUSY   = busy;
  assign bus.SEQERR = seqerr;

endmodule
